bcd_to_binary_converter: RTL

- Iterative packed-BCD to binary converter; the inverse of the team's binary-to-BCD block.
- Sits on the KPN software-program datapath where decimal-entered operands return to binary.
- Uses the reverse double-dabble algorithm (shift right, subtract 3), one iteration per clock.
- Uses a valid/ready input handshake and a one-cycle done pulse with an invalid-digit error flag.

---
 rtl/bcd_to_binary_converter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_to_binary_converter.sv
// ----------------------------------------------------------------------------
// bcd_to_binary_converter
//   Iterative packed-BCD to binary converter using reverse double-dabble:
//   each iteration shifts the working register right by one, then subtracts 3
//   from every BCD nibble that now reads >= 8. After BIN_W iterations the low
//   BIN_W bits hold the binary value. State updates on the falling clock edge.
//
// Ports
//   clk            clock (state updates on negedge)
//   reset_n        asynchronous active-low reset
//   in_valid       request to convert bcd_number
//   in_ready       block idle, request will be accepted
//   bcd_number     packed BCD operand, MS digit in top nibble
//   out_valid      one-cycle pulse: conversion done or operand rejected
//   binary_number  result, held until the next out_valid
//   bcd_error      qualifies out_valid; operand had a nibble > 9
// ----------------------------------------------------------------------------
module bcd_to_binary_converter #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_number,
   output logic                  out_valid,
   output logic [BIN_W-1:0]      binary_number,
   output logic                  bcd_error
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SH_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SH_W-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic               out_valid_q, out_valid_d;
   logic               bcd_error_q, bcd_error_d;
   // Rejected operand: DONE is entered one edge early, so the pulse is
   // emitted on the following edge.
   logic               err_pend_q, err_pend_d;

   logic               digit_bad;
   logic [SH_W-1:0]    shift_step;

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_number[4*i +: 4] > 4'd9) digit_bad = 1'b1;
      end
   end

   // One reverse double-dabble iteration; all digit corrections in parallel.
   always_comb begin
      shift_step = shift_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (shift_step[BIN_W + 4*i +: 4] >= 4'd8)
            shift_step[BIN_W + 4*i +: 4] = shift_step[BIN_W + 4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      bin_d       = bin_q;
      out_valid_d = 1'b0;
      bcd_error_d = 1'b0;
      err_pend_d  = err_pend_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (digit_bad) begin
                  err_pend_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  shift_d = {bcd_number, {BIN_W{1'b0}}};
                  cnt_d   = '0;
                  state_d = CONVERT;
               end
            end
         end
         CONVERT: begin
            shift_d = shift_step;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               bin_d       = shift_step[BIN_W-1:0];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (err_pend_q) begin
               bin_d       = '0;
               out_valid_d = 1'b1;
               bcd_error_d = 1'b1;
               err_pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         bin_q       <= '0;
         out_valid_q <= 1'b0;
         bcd_error_q <= 1'b0;
         err_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         bin_q       <= bin_d;
         out_valid_q <= out_valid_d;
         bcd_error_q <= bcd_error_d;
         err_pend_q  <= err_pend_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = out_valid_q;
   assign binary_number = bin_q;
   assign bcd_error     = bcd_error_q;

endmodule
